// File: rtl/rf_mode_sequencer.sv
// rf_mode_sequencer: synchronises and debounces the MCU mode pins, then applies
// a new mode only after UART traffic drains and busy sources clear. AUX is held
// low for a programmable switch time while the change is applied.
module rf_mode_sequencer #(
  parameter int                    MODE_WIDTH         = 2,
  parameter logic [MODE_WIDTH-1:0] DEFAULT_MODE       = '0,
  parameter int                    SYNC_STAGES        = 2,
  parameter int                    NUM_BUSY_SRC       = 3,
  parameter int                    DEBOUNCE_CYCLES    = 16,
  parameter int                    END_POWER_ON_CHECK = 750000,
  parameter int                    END_MODE_SWITCH    = 15000,
  parameter int                    CNT_WIDTH          = 24
) (
  input  logic                    internal_clk,
  input  logic                    rst,
  input  logic [MODE_WIDTH-1:0]   mode_pins,
  input  logic [NUM_BUSY_SRC-1:0] busy_in,
  input  logic                    tx_drain_done,
  output logic [MODE_WIDTH-1:0]   mode_sync,
  output logic                    mode_change,
  output logic                    switch_pending,
  output logic                    AUX,
  output logic [2:0]              seq_state
);

  localparam logic [2:0] ST_POWER_ON = 3'd0;
  localparam logic [2:0] ST_IDLE     = 3'd1;
  localparam logic [2:0] ST_DEBOUNCE = 3'd2;
  localparam logic [2:0] ST_DRAIN    = 3'd3;
  localparam logic [2:0] ST_SWITCH   = 3'd4;

  localparam logic [CNT_WIDTH-1:0] LOAD_POWER_ON = CNT_WIDTH'(END_POWER_ON_CHECK - 1);
  localparam logic [CNT_WIDTH-1:0] LOAD_DEBOUNCE = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LOAD_SWITCH   = CNT_WIDTH'(END_MODE_SWITCH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE       = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO      = '0;

  logic [MODE_WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [MODE_WIDTH-1:0] w_pinSync;

  logic [2:0]            r_state;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [MODE_WIDTH-1:0] r_target;
  logic [MODE_WIDTH-1:0] r_mode;
  logic                  r_change;
  logic                  r_pending;
  logic                  r_aux;

  logic [2:0]            w_stateNext;
  logic [CNT_WIDTH-1:0]  w_cntNext;
  logic [MODE_WIDTH-1:0] w_targetNext;
  logic [MODE_WIDTH-1:0] w_modeNext;
  logic                  w_changeNext;
  logic                  w_pendingNext;
  logic                  w_drainOk;
  logic                  w_cntZero;

  assign w_pinSync = r_sync[SYNC_STAGES-1];
  assign w_drainOk = tx_drain_done & ~(|busy_in);
  assign w_cntZero = (r_cnt == CNT_ZERO);

  // Multi-stage synchroniser on the asynchronous mode pins, preloaded with the default mode
  always_ff @(posedge internal_clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= DEFAULT_MODE;
      end
    end else begin
      r_sync[0] <= mode_pins;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  // Next-state logic; the shared counter only decrements when nonzero so it never wraps
  always_comb begin
    w_stateNext   = r_state;
    w_cntNext     = r_cnt;
    w_targetNext  = r_target;
    w_modeNext    = r_mode;
    w_changeNext  = 1'b0;
    w_pendingNext = r_pending;
    case (r_state)
      ST_POWER_ON: begin
        if (w_cntZero) begin
          w_stateNext = ST_IDLE;
        end else begin
          w_cntNext = r_cnt - CNT_ONE;
        end
      end
      ST_IDLE: begin
        if (w_pinSync != r_mode) begin
          w_targetNext = w_pinSync;
          w_cntNext    = LOAD_DEBOUNCE;
          w_stateNext  = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (w_pinSync != r_target) begin
          w_stateNext = ST_IDLE;
        end else if (w_cntZero) begin
          w_pendingNext = 1'b1;
          w_stateNext   = ST_DRAIN;
        end else begin
          w_cntNext = r_cnt - CNT_ONE;
        end
      end
      ST_DRAIN: begin
        if (w_drainOk) begin
          w_cntNext   = LOAD_SWITCH;
          w_stateNext = ST_SWITCH;
        end
      end
      ST_SWITCH: begin
        if (w_cntZero) begin
          w_modeNext    = r_target;
          w_changeNext  = 1'b1;
          w_pendingNext = 1'b0;
          w_stateNext   = ST_IDLE;
        end else begin
          w_cntNext = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any sequence in flight without a mode_change pulse
  always_ff @(posedge internal_clk) begin
    if (rst) begin
      r_state   <= ST_POWER_ON;
      r_cnt     <= LOAD_POWER_ON;
      r_target  <= DEFAULT_MODE;
      r_mode    <= DEFAULT_MODE;
      r_change  <= 1'b0;
      r_pending <= 1'b0;
      r_aux     <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_cnt     <= w_cntNext;
      r_target  <= w_targetNext;
      r_mode    <= w_modeNext;
      r_change  <= w_changeNext;
      r_pending <= w_pendingNext;
      r_aux     <= (w_stateNext == ST_IDLE) & w_drainOk;
    end
  end

  assign mode_sync      = r_mode;
  assign mode_change    = r_change;
  assign switch_pending = r_pending;
  assign AUX            = r_aux;
  assign seq_state      = r_state;

endmodule

// File: tb/tb_rf_mode_sequencer.sv
// tb_rf_mode_sequencer: table-driven and hand-sequenced checks of the mode sequencer
// using short power-on, debounce and switch times.
module tb_rf_mode_sequencer;

  logic       clk;
  logic       rst;
  logic [1:0] modePins;
  logic [2:0] busyIn;
  logic       txDrainDone;
  logic [1:0] modeSync;
  logic       modeChange;
  logic       switchPending;
  logic       aux;
  logic [2:0] seqState;

  int compared   = 0;
  int mismatched = 0;
  int pulseCount = 0;
  int pulseBase  = 0;

  typedef struct {
    logic       rstIn;
    logic [1:0] pinsIn;
    logic [2:0] busyIn;
    logic       drainIn;
    int         cycles;
    logic [1:0] expMode;
    logic       expChange;
    logic       expPend;
    logic       expAux;
    logic [2:0] expState;
  } vec_t;

  vec_t vecs[$];

  rf_mode_sequencer #(
    .MODE_WIDTH(2),
    .DEFAULT_MODE(2'd0),
    .SYNC_STAGES(2),
    .NUM_BUSY_SRC(3),
    .DEBOUNCE_CYCLES(4),
    .END_POWER_ON_CHECK(20),
    .END_MODE_SWITCH(10),
    .CNT_WIDTH(24)
  ) dut (
    .internal_clk(clk),
    .rst(rst),
    .mode_pins(modePins),
    .busy_in(busyIn),
    .tx_drain_done(txDrainDone),
    .mode_sync(modeSync),
    .mode_change(modeChange),
    .switch_pending(switchPending),
    .AUX(aux),
    .seq_state(seqState)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle in which mode_change is seen high
  always @(negedge clk) begin
    if (modeChange === 1'b1) pulseCount <= pulseCount + 1;
  end

  task automatic cmp(input string name, input string field, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s.%s: got %0d, expected %0d", name, field, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [1:0] p, input logic [2:0] b, input logic d);
    rst         = r;
    modePins    = p;
    busyIn      = b;
    txDrainDone = d;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic checkOutput(input string name, input logic [1:0] eMode, input logic eChange,
                             input logic ePend, input logic eAux, input logic [2:0] eState);
    cmp(name, "mode_sync", int'(modeSync), int'(eMode));
    cmp(name, "mode_change", int'(modeChange), int'(eChange));
    cmp(name, "switch_pending", int'(switchPending), int'(ePend));
    cmp(name, "AUX", int'(aux), int'(eAux));
    cmp(name, "seq_state", int'(seqState), int'(eState));
  endtask

  task automatic addVec(input logic r, input logic [1:0] p, input logic [2:0] b, input logic d,
                        input int n, input logic [1:0] m, input logic c, input logic pe,
                        input logic a, input logic [2:0] s);
    vec_t v;
    v.rstIn = r; v.pinsIn = p; v.busyIn = b; v.drainIn = d; v.cycles = n;
    v.expMode = m; v.expChange = c; v.expPend = pe; v.expAux = a; v.expState = s;
    vecs.push_back(v);
  endtask

  task automatic doReset(input string name);
    applyStimulus(1'b1, 2'd0, 3'b000, 1'b1);
    stepCycles(2);
    applyStimulus(1'b0, 2'd0, 3'b000, 1'b1);
    stepCycles(20);
    checkOutput(name, 2'd0, 1'b0, 1'b0, 1'b1, 3'd1);
  endtask

  initial begin
    applyStimulus(1'b1, 2'd0, 3'b000, 1'b1);

    // rst, pins, busy, drain, cycles | mode, change, pending, AUX, state
    // Power-on
    addVec(1, 2'd0, 3'b000, 1, 3,  2'd0, 0, 0, 0, 3'd0);
    addVec(0, 2'd0, 3'b000, 1, 19, 2'd0, 0, 0, 0, 3'd0);
    addVec(0, 2'd0, 3'b000, 1, 1,  2'd0, 0, 0, 1, 3'd1);
    addVec(0, 2'd0, 3'b000, 1, 5,  2'd0, 0, 0, 1, 3'd1);
    // Clean switch 0 -> 3
    addVec(0, 2'd3, 3'b000, 1, 2,  2'd0, 0, 0, 1, 3'd1);
    addVec(0, 2'd3, 3'b000, 1, 1,  2'd0, 0, 0, 0, 3'd2);
    addVec(0, 2'd3, 3'b000, 1, 3,  2'd0, 0, 0, 0, 3'd2);
    addVec(0, 2'd3, 3'b000, 1, 1,  2'd0, 0, 1, 0, 3'd3);
    addVec(0, 2'd3, 3'b000, 1, 1,  2'd0, 0, 1, 0, 3'd4);
    addVec(0, 2'd3, 3'b000, 1, 9,  2'd0, 0, 1, 0, 3'd4);
    addVec(0, 2'd3, 3'b000, 1, 1,  2'd3, 1, 0, 1, 3'd1);
    addVec(0, 2'd3, 3'b000, 1, 1,  2'd3, 0, 0, 1, 3'd1);
    // Reset back to default mode
    addVec(1, 2'd0, 3'b000, 1, 3,  2'd0, 0, 0, 0, 3'd0);
    addVec(0, 2'd0, 3'b000, 1, 20, 2'd0, 0, 0, 1, 3'd1);
    // Glitch 0 -> 2 -> 0
    addVec(0, 2'd2, 3'b000, 1, 2,  2'd0, 0, 0, 1, 3'd1);
    addVec(0, 2'd0, 3'b000, 1, 1,  2'd0, 0, 0, 0, 3'd2);
    addVec(0, 2'd0, 3'b000, 1, 1,  2'd0, 0, 0, 0, 3'd2);
    addVec(0, 2'd0, 3'b000, 1, 1,  2'd0, 0, 0, 1, 3'd1);
    addVec(0, 2'd0, 3'b000, 1, 5,  2'd0, 0, 0, 1, 3'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rstIn, vecs[i].pinsIn, vecs[i].busyIn, vecs[i].drainIn);
      stepCycles(vecs[i].cycles);
      checkOutput($sformatf("row%0d", i), vecs[i].expMode, vecs[i].expChange,
                  vecs[i].expPend, vecs[i].expAux, vecs[i].expState);
    end
    cmp("table", "pulses", pulseCount, 1);

    // Drain hold: TX not drained and one busy source set while switching to 1
    applyStimulus(1'b0, 2'd0, 3'b010, 1'b0);
    stepCycles(1);
    checkOutput("drainIdle", 2'd0, 1'b0, 1'b0, 1'b0, 3'd1);
    applyStimulus(1'b0, 2'd1, 3'b010, 1'b0);
    stepCycles(7);
    checkOutput("drainEnter", 2'd0, 1'b0, 1'b1, 1'b0, 3'd3);
    stepCycles(10);
    checkOutput("drainHold", 2'd0, 1'b0, 1'b1, 1'b0, 3'd3);
    applyStimulus(1'b0, 2'd1, 3'b010, 1'b1);
    stepCycles(3);
    checkOutput("drainBusy", 2'd0, 1'b0, 1'b1, 1'b0, 3'd3);
    applyStimulus(1'b0, 2'd1, 3'b000, 1'b1);
    stepCycles(1);
    checkOutput("drainRelease", 2'd0, 1'b0, 1'b1, 1'b0, 3'd4);
    stepCycles(9);
    checkOutput("drainSwitchEnd", 2'd0, 1'b0, 1'b1, 1'b0, 3'd4);
    stepCycles(1);
    checkOutput("drainLand", 2'd1, 1'b1, 1'b0, 1'b1, 3'd1);
    stepCycles(1);
    cmp("drain", "pulses", pulseCount, 2);

    // Pin change during SWITCH: 0 -> 1 lands first, then a fresh sequence lands 2
    doReset("reset5");
    pulseBase = pulseCount;
    applyStimulus(1'b0, 2'd1, 3'b000, 1'b1);
    stepCycles(8);
    checkOutput("midSwitch", 2'd0, 1'b0, 1'b1, 1'b0, 3'd4);
    stepCycles(3);
    applyStimulus(1'b0, 2'd2, 3'b000, 1'b1);
    stepCycles(7);
    checkOutput("firstLand", 2'd1, 1'b1, 1'b0, 1'b1, 3'd1);
    stepCycles(1);
    checkOutput("secondStart", 2'd1, 1'b0, 1'b0, 1'b0, 3'd2);
    stepCycles(15);
    checkOutput("secondLand", 2'd2, 1'b1, 1'b0, 1'b1, 3'd1);
    stepCycles(1);
    checkOutput("secondAfter", 2'd2, 1'b0, 1'b0, 1'b1, 3'd1);
    cmp("changeDuringSwitch", "pulses", pulseCount - pulseBase, 2);

    // Reset asserted mid-SWITCH
    pulseBase = pulseCount;
    applyStimulus(1'b0, 2'd3, 3'b000, 1'b1);
    stepCycles(10);
    checkOutput("preReset", 2'd2, 1'b0, 1'b1, 1'b0, 3'd4);
    applyStimulus(1'b1, 2'd3, 3'b000, 1'b1);
    stepCycles(1);
    checkOutput("resetHit", 2'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    applyStimulus(1'b0, 2'd3, 3'b000, 1'b1);
    stepCycles(19);
    checkOutput("resetPowerOn", 2'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    stepCycles(1);
    checkOutput("resetIdle", 2'd0, 1'b0, 1'b0, 1'b1, 3'd1);
    cmp("resetMidSwitch", "pulses", pulseCount - pulseBase, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
